// File: rtl/byteunstuffer_if.sv
// Byte-stream bus for the JPEG byte unstuffer: raw input bytes in,
// destuffed data/marker entries out with ready/valid and a sticky overflow.
interface byteunstuffer_if;
  logic       data_in_valid;
  logic [7:0] data_in;
  logic       data_out_ready;
  logic       data_out_valid;
  logic [7:0] data_out;
  logic       data_out_is_marker;
  logic       overflow;

  modport master (
    output data_in_valid, data_in, data_out_ready,
    input  data_out_valid, data_out, data_out_is_marker, overflow
  );

  modport slave (
    input  data_in_valid, data_in, data_out_ready,
    output data_out_valid, data_out, data_out_is_marker, overflow
  );
endinterface

// File: rtl/byteunstuffer.sv
// JPEG entropy-segment byte unstuffer: drops the 0x00 after 0xFF, skips fill
// bytes, tags markers, and queues results in a small ready/valid output FIFO.
module byteunstuffer #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic            clock,
  input  logic            nreset,
  byteunstuffer_if.slave  bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH_LOG2 < 1) ? 1 : FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DEPTH = 1 << PTR_W;

  typedef struct packed {
    logic       is_marker;
    logic [7:0] data;
  } entry_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SAW_FF = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               push_c;
  entry_t             push_entry_c;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               full_c, pop_c, wr_c;
  entry_t             head_c;

  // Parser state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= ST_NORMAL;
    else         state_q <= state_d;
  end

  // Parser next state and push request
  always_comb begin
    state_d      = state_q;
    push_c       = 1'b0;
    push_entry_c = '0;
    if (bus.data_in_valid) begin
      unique case (state_q)
        ST_NORMAL: begin
          if (bus.data_in == 8'hFF) begin
            state_d = ST_SAW_FF;
          end else begin
            push_c       = 1'b1;
            push_entry_c = '{is_marker: 1'b0, data: bus.data_in};
          end
        end
        ST_SAW_FF: begin
          if (bus.data_in == 8'h00) begin
            push_c       = 1'b1;
            push_entry_c = '{is_marker: 1'b0, data: 8'hFF};
            state_d      = ST_NORMAL;
          end else if (bus.data_in != 8'hFF) begin
            push_c       = 1'b1;
            push_entry_c = '{is_marker: 1'b1, data: bus.data_in};
            state_d      = ST_NORMAL;
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge
  always_comb begin
    full_c     = (count_q == CNT_W'(DEPTH));
    pop_c      = (count_q != '0) && bus.data_out_ready;
    wr_c       = push_c && (!full_c || pop_c);
    overflow_d = overflow_q | (push_c && full_c && !pop_c);
    wr_ptr_d   = wr_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as 0x00
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_c) begin
      mem_q[wr_ptr_q] <= push_entry_c;
    end
  end

  assign head_c                 = mem_q[rd_ptr_q];
  assign bus.data_out_valid     = (count_q != '0);
  assign bus.data_out           = head_c.data;
  assign bus.data_out_is_marker = head_c.is_marker;
  assign bus.overflow           = overflow_q;

endmodule

// File: tb/tb_byteunstuffer.sv
// Directed bench for byteunstuffer: per-cycle vector table plus hand-written
// sequences for full/overflow/reset corner cases.
module tb_byteunstuffer;

  logic clock;
  logic nreset;
  int   checks;
  int   errors;

  byteunstuffer_if bus ();

  byteunstuffer #(.FIFO_DEPTH_LOG2(4)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_mk;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
    bus.data_in_valid  = v;
    bus.data_in        = d;
    bus.data_out_ready = rdy;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed, input logic em);
    vec_t r;
    r.v = v; r.d = d; r.rdy = 1'b1;
    r.exp_valid = ev; r.exp_data = ed; r.exp_mk = em;
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    nreset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) step();

    chk("reset_valid",  32'(bus.data_out_valid), 32'd0);
    chk("reset_data",   32'(bus.data_out), 32'h00);
    chk("reset_marker", 32'(bus.data_out_is_marker), 32'd0);
    chk("reset_ovf",    32'(bus.overflow), 32'd0);
    nreset = 1'b1;
    step();

    // Destuffing: 12 34 FF 00 56 FF 00, then idle
    vq.push_back(mk(1, 8'h12, 1, 8'h12, 0));
    vq.push_back(mk(1, 8'h34, 1, 8'h34, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'h00, 1, 8'hFF, 0));
    vq.push_back(mk(1, 8'h56, 1, 8'h56, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'h00, 1, 8'hFF, 0));
    vq.push_back(mk(0, 8'h00, 0, 8'h00, 0));
    // Markers and fill: AA FF FF FF D0 BB FF D9
    vq.push_back(mk(1, 8'hAA, 1, 8'hAA, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'hD0, 1, 8'hD0, 1));
    vq.push_back(mk(1, 8'hBB, 1, 8'hBB, 0));
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'hD9, 1, 8'hD9, 1));
    vq.push_back(mk(0, 8'h00, 0, 8'h00, 0));
    // Idle gap between FF and 00
    vq.push_back(mk(1, 8'hFF, 0, 8'h00, 0));
    for (int i = 0; i < 7; i++) vq.push_back(mk(0, 8'h00, 0, 8'h00, 0));
    vq.push_back(mk(1, 8'h00, 1, 8'hFF, 0));
    vq.push_back(mk(0, 8'h00, 0, 8'h00, 0));

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].d, vq[i].rdy);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.data_out_valid), 32'(vq[i].exp_valid));
      if (vq[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 32'(bus.data_out), 32'(vq[i].exp_data));
        chk($sformatf("vec%0d_marker", i), 32'(bus.data_out_is_marker), 32'(vq[i].exp_mk));
      end
    end
    chk("table_ovf", 32'(bus.overflow), 32'd0);

    // Full plus simultaneous pop: 0x30..0x3F fill, then 0x20 with a pop
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0);
      step();
    end
    chk("full_head", 32'(bus.data_out), 32'h30);
    drive(1'b1, 8'h20, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("fullpop_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpop_valid%0d", i), 32'(bus.data_out_valid), 32'd1);
      chk($sformatf("fullpop_data%0d", i), 32'(bus.data_out),
          (i < 15) ? 32'(8'h31 + i) : 32'h20);
      drive(1'b0, 8'h00, 1'b1);
      step();
    end
    chk("fullpop_empty", 32'(bus.data_out_valid), 32'd0);

    // Overflow: push 0x01..0x11 with no pops
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      step();
      if (i == 16) chk("ovf_before", 32'(bus.overflow), 32'd0);
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("ovf_rise", 32'(bus.overflow), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain_valid%0d", i), 32'(bus.data_out_valid), 32'd1);
      chk($sformatf("drain_data%0d", i), 32'(bus.data_out), 32'(i));
      drive(1'b0, 8'h00, 1'b1);
      step();
    end
    chk("drain_empty", 32'(bus.data_out_valid), 32'd0);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Mid-stream reset with 3 entries queued and an FF pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h41 + i), 1'b0);
      step();
    end
    drive(1'b1, 8'hFF, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    chk("pre_reset_valid", 32'(bus.data_out_valid), 32'd1);
    nreset = 1'b0;
    #1;
    chk("midreset_valid", 32'(bus.data_out_valid), 32'd0);
    chk("midreset_ovf",   32'(bus.overflow), 32'd0);
    step();
    nreset = 1'b1;
    step();
    drive(1'b1, 8'h00, 1'b1);
    step();
    chk("post_reset_valid",  32'(bus.data_out_valid), 32'd1);
    chk("post_reset_data",   32'(bus.data_out), 32'h00);
    chk("post_reset_marker", 32'(bus.data_out_is_marker), 32'd0);
    drive(1'b0, 8'h00, 1'b1);
    step();
    chk("post_reset_empty", 32'(bus.data_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byteunstuffer.md
# byteunstuffer

Receive-side inverse of the JPEG entropy-segment byte stuffer. The block accepts a raw scan byte stream and drops every 0x00 that follows a 0xFF. It discards 0xFF fill bytes and recognises 0xFF-prefixed markers. Data bytes and markers are emitted in original order through a small output FIFO with ready/valid backpressure. It sits at the front of the decode path, between the byte source and the Huffman/bitstream reader.

## Interface
- FIFO_DEPTH_LOG2, 4, log2 of output FIFO depth in entries; depth = 2^FIFO_DEPTH_LOG2, minimum 1.

- clock  input  1  single clock; all state changes on rising edge.
- nreset  input  1  asynchronous, active-low reset.
- data_in_valid  input  1  data_in carries a byte this cycle. No backpressure: the block always accepts it.
- data_in  input  8  stuffed input byte.
- data_out_ready  input  1  consumer takes the head entry this cycle if data_out_valid.
- data_out_valid  output  1  FIFO not empty.
- data_out  output  8  head entry payload: a data byte, or the marker code.
- data_out_is_marker  output  1  head entry is a marker; data_out is the code following 0xFF.
- overflow  output  1  sticky. An entry was dropped because the FIFO was full.

## Operation
- Two-state parser, NORMAL and SAW_FF. It advances only on edges where data_in_valid=1.
- In NORMAL:
  - A byte other than 0xFF pushes {0, byte}; the state stays NORMAL.
  - 0xFF pushes nothing and moves to SAW_FF.
- In SAW_FF:
  - 0x00 pushes {0, 0xFF} and moves to NORMAL.
  - 0xFF is a fill byte: nothing is pushed and the state stays SAW_FF.
  - Any other value v pushes {1, v} and moves to NORMAL. All markers are treated alike, including RSTn, EOI and SOS.
- Idle cycles (data_in_valid=0) never change parser state. A pending 0xFF waits indefinitely for its next byte.
- FIFO: 9-bit entries, circular buffer with read/write pointers and an occupancy count 0..depth.
  - Pointers wrap modulo depth.
  - Pop occurs when data_out_valid && data_out_ready.
- Push when full:
  - With a simultaneous pop, the push succeeds and the count is unchanged.
  - Without a pop, the entry is discarded and overflow is set. overflow stays 1 until reset.
  - The parser state still advances normally.
- Push and pop in the same cycle with count between 1 and depth-1: the count is unchanged and both pointers advance.
- data_out and data_out_is_marker are driven directly from the head entry. Their value is don't-care when data_out_valid=0.

## Timing
- Reset (asynchronous assert, synchronous to clock on release):
  - state NORMAL, FIFO empty, pointers 0, overflow 0.
  - data_out_valid 0, data_out 0x00, data_out_is_marker 0.
- Reset mid-operation discards any pending 0xFF and all FIFO contents.
- Latency, input to output:
  - A byte sampled on edge N that produces an entry into an empty FIFO makes data_out_valid 1 after edge N (cycle N+1).
  - A 0xFF/0x00 pair produces its output one cycle after the 0x00 is sampled.
- Throughput: at most one push and one pop per cycle. Sustained input of one byte per cycle is supported when data_out_ready is held 1.
- Pop: with data_out_ready=1 on edge M, the next entry (or data_out_valid=0) appears after edge M.
- overflow rises after the edge on which the dropped push occurred.

## Test plan
- Reset: assert nreset=0 mid-stream with the FIFO holding 3 entries -> data_out_valid=0 and overflow=0 immediately. Then feed 0x00 as the first byte after release -> output {0, 0x00}, with no 0xFF emitted.
- Destuffing: input 12 34 FF 00 56 FF 00, data_out_ready=1 -> outputs 12, 34, FF, 56, FF, all with is_marker=0. data_out_valid is low on exactly the two cycles following the FF inputs.
- Markers and fill: input AA FF FF FF D0 BB FF D9 -> AA, marker D0, BB, marker D9, in that order. The fill bytes produce no entries.
- Idle gaps: FF, then 7 cycles with data_in_valid=0, then 00 -> a single {0, FF}, with no entry during the gap.
- Overflow: depth 16, data_out_ready=0, push bytes 0x01..0x11 -> 16 entries 0x01..0x10 retained. overflow rises after the 0x11 edge and stays 1. Draining then yields exactly 0x01..0x10.
- Full plus simultaneous pop: fill to 16, then push 0x20 on the same edge as a pop -> no overflow, count stays 16, and 0x20 is the last entry drained.
